// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES-128 key-schedule constants and helpers
//             (Rcon byte table, round count, RotWord).
//  Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    // Number of AES-128 rounds; also the number of valid Rcon entries.
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Round-constant bytes RC(0)..RC(9); RC(i) for i >= 10 is zero.
    localparam logic [7:0] RCON_TABLE [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round-constant byte lookup with zero beyond the last round.
    function automatic logic [7:0] rc_byte(input logic [3:0] idx);
        if (idx < NUM_ROUNDS)
            return RCON_TABLE[idx];
        else
            return 8'h00;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox
//  Purpose  : AES forward S-box, purely combinational 8-bit lookup.
//  Revision : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    // Full 256-entry forward substitution table.
    always_comb begin
        d = 8'h00;
        case (a)
            8'h00: d = 8'h63; 8'h01: d = 8'h7c; 8'h02: d = 8'h77; 8'h03: d = 8'h7b; 8'h04: d = 8'hf2; 8'h05: d = 8'h6b; 8'h06: d = 8'h6f; 8'h07: d = 8'hc5;
            8'h08: d = 8'h30; 8'h09: d = 8'h01; 8'h0a: d = 8'h67; 8'h0b: d = 8'h2b; 8'h0c: d = 8'hfe; 8'h0d: d = 8'hd7; 8'h0e: d = 8'hab; 8'h0f: d = 8'h76;
            8'h10: d = 8'hca; 8'h11: d = 8'h82; 8'h12: d = 8'hc9; 8'h13: d = 8'h7d; 8'h14: d = 8'hfa; 8'h15: d = 8'h59; 8'h16: d = 8'h47; 8'h17: d = 8'hf0;
            8'h18: d = 8'had; 8'h19: d = 8'hd4; 8'h1a: d = 8'ha2; 8'h1b: d = 8'haf; 8'h1c: d = 8'h9c; 8'h1d: d = 8'ha4; 8'h1e: d = 8'h72; 8'h1f: d = 8'hc0;
            8'h20: d = 8'hb7; 8'h21: d = 8'hfd; 8'h22: d = 8'h93; 8'h23: d = 8'h26; 8'h24: d = 8'h36; 8'h25: d = 8'h3f; 8'h26: d = 8'hf7; 8'h27: d = 8'hcc;
            8'h28: d = 8'h34; 8'h29: d = 8'ha5; 8'h2a: d = 8'he5; 8'h2b: d = 8'hf1; 8'h2c: d = 8'h71; 8'h2d: d = 8'hd8; 8'h2e: d = 8'h31; 8'h2f: d = 8'h15;
            8'h30: d = 8'h04; 8'h31: d = 8'hc7; 8'h32: d = 8'h23; 8'h33: d = 8'hc3; 8'h34: d = 8'h18; 8'h35: d = 8'h96; 8'h36: d = 8'h05; 8'h37: d = 8'h9a;
            8'h38: d = 8'h07; 8'h39: d = 8'h12; 8'h3a: d = 8'h80; 8'h3b: d = 8'he2; 8'h3c: d = 8'heb; 8'h3d: d = 8'h27; 8'h3e: d = 8'hb2; 8'h3f: d = 8'h75;
            8'h40: d = 8'h09; 8'h41: d = 8'h83; 8'h42: d = 8'h2c; 8'h43: d = 8'h1a; 8'h44: d = 8'h1b; 8'h45: d = 8'h6e; 8'h46: d = 8'h5a; 8'h47: d = 8'ha0;
            8'h48: d = 8'h52; 8'h49: d = 8'h3b; 8'h4a: d = 8'hd6; 8'h4b: d = 8'hb3; 8'h4c: d = 8'h29; 8'h4d: d = 8'he3; 8'h4e: d = 8'h2f; 8'h4f: d = 8'h84;
            8'h50: d = 8'h53; 8'h51: d = 8'hd1; 8'h52: d = 8'h00; 8'h53: d = 8'hed; 8'h54: d = 8'h20; 8'h55: d = 8'hfc; 8'h56: d = 8'hb1; 8'h57: d = 8'h5b;
            8'h58: d = 8'h6a; 8'h59: d = 8'hcb; 8'h5a: d = 8'hbe; 8'h5b: d = 8'h39; 8'h5c: d = 8'h4a; 8'h5d: d = 8'h4c; 8'h5e: d = 8'h58; 8'h5f: d = 8'hcf;
            8'h60: d = 8'hd0; 8'h61: d = 8'hef; 8'h62: d = 8'haa; 8'h63: d = 8'hfb; 8'h64: d = 8'h43; 8'h65: d = 8'h4d; 8'h66: d = 8'h33; 8'h67: d = 8'h85;
            8'h68: d = 8'h45; 8'h69: d = 8'hf9; 8'h6a: d = 8'h02; 8'h6b: d = 8'h7f; 8'h6c: d = 8'h50; 8'h6d: d = 8'h3c; 8'h6e: d = 8'h9f; 8'h6f: d = 8'ha8;
            8'h70: d = 8'h51; 8'h71: d = 8'ha3; 8'h72: d = 8'h40; 8'h73: d = 8'h8f; 8'h74: d = 8'h92; 8'h75: d = 8'h9d; 8'h76: d = 8'h38; 8'h77: d = 8'hf5;
            8'h78: d = 8'hbc; 8'h79: d = 8'hb6; 8'h7a: d = 8'hda; 8'h7b: d = 8'h21; 8'h7c: d = 8'h10; 8'h7d: d = 8'hff; 8'h7e: d = 8'hf3; 8'h7f: d = 8'hd2;
            8'h80: d = 8'hcd; 8'h81: d = 8'h0c; 8'h82: d = 8'h13; 8'h83: d = 8'hec; 8'h84: d = 8'h5f; 8'h85: d = 8'h97; 8'h86: d = 8'h44; 8'h87: d = 8'h17;
            8'h88: d = 8'hc4; 8'h89: d = 8'ha7; 8'h8a: d = 8'h7e; 8'h8b: d = 8'h3d; 8'h8c: d = 8'h64; 8'h8d: d = 8'h5d; 8'h8e: d = 8'h19; 8'h8f: d = 8'h73;
            8'h90: d = 8'h60; 8'h91: d = 8'h81; 8'h92: d = 8'h4f; 8'h93: d = 8'hdc; 8'h94: d = 8'h22; 8'h95: d = 8'h2a; 8'h96: d = 8'h90; 8'h97: d = 8'h88;
            8'h98: d = 8'h46; 8'h99: d = 8'hee; 8'h9a: d = 8'hb8; 8'h9b: d = 8'h14; 8'h9c: d = 8'hde; 8'h9d: d = 8'h5e; 8'h9e: d = 8'h0b; 8'h9f: d = 8'hdb;
            8'ha0: d = 8'he0; 8'ha1: d = 8'h32; 8'ha2: d = 8'h3a; 8'ha3: d = 8'h0a; 8'ha4: d = 8'h49; 8'ha5: d = 8'h06; 8'ha6: d = 8'h24; 8'ha7: d = 8'h5c;
            8'ha8: d = 8'hc2; 8'ha9: d = 8'hd3; 8'haa: d = 8'hac; 8'hab: d = 8'h62; 8'hac: d = 8'h91; 8'had: d = 8'h95; 8'hae: d = 8'he4; 8'haf: d = 8'h79;
            8'hb0: d = 8'he7; 8'hb1: d = 8'hc8; 8'hb2: d = 8'h37; 8'hb3: d = 8'h6d; 8'hb4: d = 8'h8d; 8'hb5: d = 8'hd5; 8'hb6: d = 8'h4e; 8'hb7: d = 8'ha9;
            8'hb8: d = 8'h6c; 8'hb9: d = 8'h56; 8'hba: d = 8'hf4; 8'hbb: d = 8'hea; 8'hbc: d = 8'h65; 8'hbd: d = 8'h7a; 8'hbe: d = 8'hae; 8'hbf: d = 8'h08;
            8'hc0: d = 8'hba; 8'hc1: d = 8'h78; 8'hc2: d = 8'h25; 8'hc3: d = 8'h2e; 8'hc4: d = 8'h1c; 8'hc5: d = 8'ha6; 8'hc6: d = 8'hb4; 8'hc7: d = 8'hc6;
            8'hc8: d = 8'he8; 8'hc9: d = 8'hdd; 8'hca: d = 8'h74; 8'hcb: d = 8'h1f; 8'hcc: d = 8'h4b; 8'hcd: d = 8'hbd; 8'hce: d = 8'h8b; 8'hcf: d = 8'h8a;
            8'hd0: d = 8'h70; 8'hd1: d = 8'h3e; 8'hd2: d = 8'hb5; 8'hd3: d = 8'h66; 8'hd4: d = 8'h48; 8'hd5: d = 8'h03; 8'hd6: d = 8'hf6; 8'hd7: d = 8'h0e;
            8'hd8: d = 8'h61; 8'hd9: d = 8'h35; 8'hda: d = 8'h57; 8'hdb: d = 8'hb9; 8'hdc: d = 8'h86; 8'hdd: d = 8'hc1; 8'hde: d = 8'h1d; 8'hdf: d = 8'h9e;
            8'he0: d = 8'he1; 8'he1: d = 8'hf8; 8'he2: d = 8'h98; 8'he3: d = 8'h11; 8'he4: d = 8'h69; 8'he5: d = 8'hd9; 8'he6: d = 8'h8e; 8'he7: d = 8'h94;
            8'he8: d = 8'h9b; 8'he9: d = 8'h1e; 8'hea: d = 8'h87; 8'heb: d = 8'he9; 8'hec: d = 8'hce; 8'hed: d = 8'h55; 8'hee: d = 8'h28; 8'hef: d = 8'hdf;
            8'hf0: d = 8'h8c; 8'hf1: d = 8'ha1; 8'hf2: d = 8'h89; 8'hf3: d = 8'h0d; 8'hf4: d = 8'hbf; 8'hf5: d = 8'he6; 8'hf6: d = 8'h42; 8'hf7: d = 8'h68;
            8'hf8: d = 8'h41; 8'hf9: d = 8'h99; 8'hfa: d = 8'h2d; 8'hfb: d = 8'h0f; 8'hfc: d = 8'hb0; 8'hfd: d = 8'h54; 8'hfe: d = 8'hbb; 8'hff: d = 8'h16;
        endcase
    end

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_key_schedule_128.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_schedule_128
//  Purpose  : Iterative AES-128 key expansion. Loads the cipher key on kld
//             and produces one 128-bit round key per clock thereafter.
//  Revision : 1.0  initial release
// ============================================================================
module aes_key_schedule_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rcon;
    logic [3:0]  rcnt;

    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] t;
    logic [3:0]  rcnt_next;

    assign rot_w3 = rot_word(w3);

    // SubWord: one S-box per byte of the rotated last word.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (
                .a (rot_w3[i*8 +: 8]),
                .d (sub_w3[i*8 +: 8])
            );
        end
    endgenerate

    assign t = sub_w3 ^ rcon;

    // Round counter saturates so rcon stays zero once the schedule is spent.
    assign rcnt_next = (rcnt == 4'hf) ? rcnt : rcnt + 4'd1;

    // Round-key state: reset clears, load takes the key, otherwise advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w0   <= 32'h0;
            w1   <= 32'h0;
            w2   <= 32'h0;
            w3   <= 32'h0;
            rcnt <= 4'd0;
            rcon <= 32'h0100_0000;
        end else if (kld) begin
            w0   <= key[127:96];
            w1   <= key[95:64];
            w2   <= key[63:32];
            w3   <= key[31:0];
            rcnt <= 4'd0;
            rcon <= 32'h0100_0000;
        end else begin
            w0   <= w0 ^ t;
            w1   <= w0 ^ w1 ^ t;
            w2   <= w0 ^ w1 ^ w2 ^ t;
            w3   <= w0 ^ w1 ^ w2 ^ w3 ^ t;
            rcnt <= rcnt_next;
            rcon <= {rc_byte(rcnt_next), 24'h0};
        end
    end

    assign wo_0 = w0;
    assign wo_1 = w1;
    assign wo_2 = w2;
    assign wo_3 = w3;

endmodule : aes_key_schedule_128
`default_nettype wire

// File: tb/tb_aes_key_schedule_128.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_schedule_128
//  Purpose  : Scoreboard bench for aes_key_schedule_128 with directed
//             FIPS-197 and zero-key vectors plus an S-box sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule_128;

    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [127:0] wo;
    logic [7:0]   sb_a;
    logic [7:0]   sb_d;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } exp_t;

    exp_t         sbq[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] fips_rk [0:11];
    logic [127:0] fips_key;
    logic [127:0] z1, z2, z3;
    logic [2047:0] gold;

    always #5 clk = ~clk;

    aes_key_schedule_128 dut (
        .clk  (clk),
        .rst  (rst),
        .kld  (kld),
        .key  (key),
        .wo_0 (wo_0),
        .wo_1 (wo_1),
        .wo_2 (wo_2),
        .wo_3 (wo_3)
    );

    aes_sbox u_sbox_ref (
        .a (sb_a),
        .d (sb_d)
    );

    assign wo = {wo_0, wo_1, wo_2, wo_3};

    function automatic void cmp(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drive one cycle of stimulus and queue the round key expected after the edge.
    task automatic step(input logic k, input logic [127:0] kv,
                        input logic [127:0] exp, input string name);
        exp_t e;
        kld = k;
        key = kv;
        @(posedge clk);
        #1;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: compare the presented round key against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp(e.name, wo, e.exp);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fips_key    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        fips_rk[0]  = fips_key;
        fips_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fips_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        fips_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        fips_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        fips_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        fips_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        fips_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        fips_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        fips_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        fips_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        // One step past round 10 with rcon = 0.
        fips_rk[11] = 128'h2beadde6_e204f86f_033bf4a7_b558f801;
        z1 = 128'h62636363_62636363_62636363_62636363;
        z2 = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
        z3 = 128'h90973450_696ccffa_f2f45733_0b0fac99;
        gold = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

        // Power-up reset, including kld held during reset.
        rst  = 1'b0;
        kld  = 1'b0;
        key  = '0;
        sb_a = 8'h00;
        #12;
        cmp("reset state", wo, 128'h0);
        kld = 1'b1;
        key = fips_key;
        @(posedge clk);
        #1;
        cmp("reset kld ignored", wo, 128'h0);
        rst = 1'b1;
        kld = 1'b0;

        // S-box sweep against the golden table.
        for (int i = 0; i < 256; i++) begin
            sb_a = 8'(i);
            #1;
            cmp($sformatf("sbox[%02h]", i), {120'h0, sb_d}, {120'h0, gold[2047-8*i -: 8]});
        end

        // FIPS-197 A.1 full schedule plus one post-round-10 step.
        step(1'b1, fips_key, fips_rk[0], "fips rk0");
        for (int k = 1; k <= 11; k++)
            step(1'b0, fips_key, fips_rk[k], $sformatf("fips rk%0d", k));

        // All-zero key.
        step(1'b1, 128'h0, 128'h0, "zero rk0");
        step(1'b0, 128'h0, z1, "zero rk1");
        step(1'b0, 128'h0, z2, "zero rk2");
        step(1'b0, 128'h0, z3, "zero rk3");

        // Reload with the zero key after round 4 of the FIPS schedule.
        step(1'b1, fips_key, fips_rk[0], "reload fips rk0");
        for (int k = 1; k <= 4; k++)
            step(1'b0, fips_key, fips_rk[k], $sformatf("reload fips rk%0d", k));
        step(1'b1, 128'h0, 128'h0, "reload zero rk0");
        step(1'b0, 128'h0, z1, "reload zero rk1");

        // kld held high: key reloaded every cycle, schedule starts after release.
        for (int k = 0; k < 3; k++)
            step(1'b1, fips_key, fips_rk[0], $sformatf("hold kld %0d", k));
        step(1'b0, fips_key, fips_rk[1], "hold release rk1");
        step(1'b0, fips_key, fips_rk[2], "hold release rk2");

        // Asynchronous reset mid-schedule, away from any clock edge.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        cmp("async reset immediate", wo, 128'h0);
        step(1'b1, fips_key, 128'h0, "reset kld held 0");
        step(1'b1, fips_key, 128'h0, "reset kld held 1");
        rst = 1'b1;
        step(1'b0, fips_key, z1, "post-reset advance");
        step(1'b1, fips_key, fips_rk[0], "fresh load rk0");
        step(1'b0, fips_key, fips_rk[1], "fresh load rk1");

        // Let the monitor drain the last expectation.
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_aes_key_schedule_128
`default_nettype wire

// File: doc/aes_key_schedule_128.md
Name: aes_key_schedule_128

Overview:
- Iterative AES-128 key expansion block. Produces one 128-bit round key per clock as four 32-bit words.
- Loads the cipher key on a load strobe, then emits round keys 1..10 on consecutive cycles.
- Sits beside the cipher round datapath, which XORs wo_0..wo_3 into the state every cycle (AddRoundKey).
- Contains four byte-substitution S-boxes (SubWord) and an Rcon generator.

Parameters:
- none (AES-128 only; Nk=4, 10 rounds fixed)

Ports:
- clk   input  1    rising-edge clock
- rst   input  1    asynchronous, active-low reset
- kld   input  1    key load strobe, sampled at rising edge of clk
- key   input  128  cipher key; key[127:96] is word 0, key[31:0] is word 3
- wo_0  output 32   current round key word 0 (bytes map to state column 0, [31:24] = row 0)
- wo_1  output 32   current round key word 1
- wo_2  output 32   current round key word 2
- wo_3  output 32   current round key word 3

Behaviour:
- Registers: w0..w3 (32 b each), rcon (32 b), rcnt (4 b). Outputs wo_i = w_i directly (registered, no combinational path from inputs).
- Reset (rst=0, asynchronous): w0..w3 = 0, rcnt = 0, rcon = 32'h01000000. Reset has priority over kld at all times, including mid-schedule.
- kld=1 at edge: w0..w3 <= key[127:96], key[95:64], key[63:32], key[31:0]; rcnt <= 0; rcon <= 32'h01000000. These outputs are round key 0.
- kld=0 at edge (advance):
  - t = SubWord(RotWord(w3)) ^ rcon.
  - RotWord(w3) = {w3[23:0], w3[31:24]}. SubWord applies the FIPS-197 S-box to each byte.
  - w0 <= w0^t; w1 <= w0^w1^t; w2 <= w0^w1^w2^t; w3 <= w0^w1^w2^w3^t.
  - rcnt <= rcnt+1. rcon <= {RC(rcnt+1), 24'h0}.
  - RC(i) for i = 0..9 is 01,02,04,08,10,20,40,80,1b,36. RC(i) = 00 for i >= 10.
- Latency: kld sampled at edge E0 gives round key 0 after E0. Round key k is valid after edge Ek (k = 1..10), with one new key per cycle and no stalls.
- After round 10 the block keeps advancing with rcon = 0. Consumers ignore these outputs. rcnt saturates at 15 (no wrap).
- kld asserted mid-schedule restarts immediately from the new key; the in-flight schedule is discarded.
- kld held high continuously reloads the key every cycle.
- S-box: purely combinational 8-bit to 8-bit lookup of the full 256-entry AES forward S-box. No latency.

Decomposition:
- Shared package aes_pkg:
  - rcon byte table (10 entries)
  - round-count constant (10)
  - function rot_word
- One natural sub-module: aes_sbox (combinational 256-entry case table, ports a[7:0] -> d[7:0]), instantiated four times for SubWord.
- Rcon logic stays inline.

Test Plan:
- S-box spot checks: 00->63, 01->7c, 53->ed, 10->ca, ff->16. Sweep all 256 inputs against a golden table.
- FIPS-197 A.1 vector: kld=1 with key 2b7e151628aed2a6abf7158809cf4f3c.
  - After E0: wo = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - After E1: a0fafe17 88542cb1 23a33939 2a6c7605.
  - After E10: d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- All-zero key:
  - After E1: 62636363 62636363 62636363 62636363.
  - After E2: 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
- Reload mid-schedule: after E4 of the FIPS key, pulse kld with the zero key. The next edge gives all-zero words, and the following edge gives 62636363 x4 (rcon restarted at 01).
- Reset: assert rst=0 asynchronously mid-schedule, with no clock edge. Outputs go to 0 immediately. kld held during reset has no effect. A kld after release behaves as a fresh load.
- Continuous kld=1 for several cycles: wo stays equal to key, and the schedule starts only on the first cycle with kld=0.
